atm_auth_controller: RTL and testbench
======================================

Name: atm_auth_controller

Overview:
- Session sequencer in front of the account-lookup block.
- Latches card account number and entered PIN, then presents them to the lookup block for one evaluation cycle.
- Grants a session or reports a failure code.
- Keeps per-account wrong-PIN counters with lockout, an inactivity timeout, and an admin unlock path.
- Its outputs drive the transaction datapath (balance/withdraw/deposit), which runs only while session_valid=1.

Parameters:
- NUM_ACC, 10: number of accounts; sizes the retry and lock tables.
- MAX_TRIES, 3: consecutive wrong PINs that lock an account (1..7).
- TIMEOUT_CYC, 1000: inactivity cycles before abort (must be < 2^TMR_W).
- TMR_W, 10: timer width.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- card_in, in, 1: level; card present.
- acc_num_in, in, 4: account number on the card; sampled on card insertion.
- pin_in, in, 16: entered PIN; sampled with pin_valid.
- pin_valid, in, 1: 1-cycle strobe; PIN entry complete.
- cancel, in, 1: 1-cycle strobe; user abort.
- txn_activity, in, 1: 1-cycle strobe from the transaction datapath; restarts the timer.
- session_end, in, 1: 1-cycle strobe; transaction finished.
- admin_unlock, in, 1: 1-cycle strobe; clear the lock and counter of admin_idx.
- admin_idx, in, 4: account index to unlock.
- lk_acc_num, out, 4: registered account number to the lookup block.
- lk_pin, out, 16: registered PIN to the lookup block.
- lk_found, in, 1: combinational from the lookup block; account exists.
- lk_index, in, 4: combinational account index; valid when lk_found=1.
- lk_pin_ok, in, 1: combinational PIN match for lk_index.
- session_valid, out, 1: high in GRANTED.
- acc_index_out, out, 4: granted account index; held through GRANTED.
- auth_fail, out, 1: 1-cycle pulse on any failure.
- fail_code, out, 2: 00 no account, 01 wrong PIN, 10 locked, 11 timeout; valid with auth_fail, held until the next failure.
- tries_left, out, 3: MAX_TRIES minus the counter of the current account; updated in CHECK.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clock edge, any state): state=IDLE.
  - Every output is 0 except tries_left=MAX_TRIES.
  - All retry counters and lock bits are cleared; timer=0.
- States: IDLE, WAIT_PIN, LOOKUP, CHECK, GRANTED, HOLD.
- IDLE:
  - card_in=1: latch acc_num_in into lk_acc_num, timer=0, go to WAIT_PIN.
- WAIT_PIN (timer increments each cycle):
  - pin_valid: latch pin_in into lk_pin, go to LOOKUP.
  - Priority: card_in=0 > cancel > timeout > pin_valid.
  - card_in=0 or cancel: go to IDLE, no auth_fail.
  - Timer reaches TIMEOUT_CYC-1: auth_fail, code 11, go to HOLD.
- LOOKUP: exactly 1 cycle so lk_* settle; always go to CHECK.
- CHECK: samples lk_found, lk_index, lk_pin_ok; 1 cycle; first match applies:
  - lk_found=0 or lk_index>=NUM_ACC: code 00, go to HOLD.
  - lock[lk_index]=1: code 10, go to HOLD. The counter does not change.
  - lk_pin_ok=0: counter+1. If the new value equals MAX_TRIES, set the lock and emit code 10 (go to HOLD). Otherwise emit code 01, timer=0, and go to WAIT_PIN for a retry.
  - lk_pin_ok=1: counter=0, latch acc_index_out, go to GRANTED.
  - The auth_fail pulse is asserted in the cycle after CHECK, i.e. the first cycle of the destination state.
- GRANTED:
  - session_valid=1.
  - Timer increments; txn_activity clears it.
  - session_end, cancel or card_in=0: go to IDLE.
  - Timeout: code 11, go to HOLD.
  - session_valid drops in the cycle the new state is entered.
- HOLD: wait for card_in=0, then go to IDLE. Ignores pin_valid, cancel and txn_activity.
- Latency:
  - pin_valid to session_valid rising: 3 cycles (WAIT_PIN, LOOKUP, CHECK edges).
  - pin_valid to auth_fail: 3 cycles.
- Counters:
  - Saturate at MAX_TRIES.
  - Persist across sessions; cleared only by a correct PIN, admin_unlock, or rst.
- admin_unlock:
  - Acts in any state.
  - admin_idx>=NUM_ACC is ignored.
  - In the same cycle as a CHECK wrong-PIN update on the same index, unlock wins: counter=0, lock=0.
  - Does not change the current FSM state.
- Timer saturates and does not wrap; it is cleared on every state entry.

Test Plan:
- Correct PIN: rst, card_in=1 with acc 3, pin_valid with lookup returning found/idx 2/pin_ok → session_valid=1 three cycles after pin_valid, acc_index_out=2; session_end → IDLE, busy=0.
- Lockout: three wrong PINs on idx 4 with MAX_TRIES=3 → codes 01, 01, 10; tries_left 2, 1, 0; HOLD. Reinserting and entering the correct PIN → code 10, no grant.
- Unknown account: lk_found=0 → code 00, HOLD. HOLD exits only after card_in=0.
- Timeout: no pin_valid for 1000 cycles → auth_fail code 11 at cycle 1000. Also, in GRANTED, a txn_activity every 500 cycles keeps the session alive for 5000 cycles.
- Admin unlock after lockout of idx 4 → correct PIN grants. Unlock coinciding with a CHECK wrong PIN on idx 4 → counter=0.
- rst asserted mid-GRANTED and mid-LOOKUP → next cycle IDLE with all outputs and locks cleared.

Source files
------------

// File: rtl/atm_auth_controller.sv
// atm_auth_controller: card/PIN session sequencer in front of the account lookup.
// Latches card number and PIN, evaluates the lookup result for one cycle, and
// either grants a session or reports a failure code. It keeps per-account
// wrong-PIN counters with lockout, an inactivity timer and an admin unlock path.
module atm_auth_controller #(
  parameter int NUM_ACC     = 10,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int TMR_W       = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic [3:0]  acc_num_in,
  input  logic [15:0] pin_in,
  input  logic        pin_valid,
  input  logic        cancel,
  input  logic        txn_activity,
  input  logic        session_end,
  input  logic        admin_unlock,
  input  logic [3:0]  admin_idx,
  output logic [3:0]  lk_acc_num,
  output logic [15:0] lk_pin,
  input  logic        lk_found,
  input  logic [3:0]  lk_index,
  input  logic        lk_pin_ok,
  output logic        session_valid,
  output logic [3:0]  acc_index_out,
  output logic        auth_fail,
  output logic [1:0]  fail_code,
  output logic [2:0]  tries_left,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PIN = 3'd1,
    S_LOOKUP   = 3'd2,
    S_CHECK    = 3'd3,
    S_GRANTED  = 3'd4,
    S_HOLD     = 3'd5
  } state_t;

  localparam logic [2:0]       MAX_T     = 3'(MAX_TRIES);
  localparam logic [4:0]       NUM_ACC_L = 5'(NUM_ACC);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_SAT   = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [1:0]       CODE_NOACC = 2'b00;
  localparam logic [1:0]       CODE_WRONG = 2'b01;
  localparam logic [1:0]       CODE_LOCK  = 2'b10;
  localparam logic [1:0]       CODE_TMO   = 2'b11;

  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic [3:0]         r_lk_acc;
  logic [15:0]        r_lk_pin;
  logic               r_sess;
  logic [3:0]         r_acc_idx;
  logic               r_fail;
  logic [1:0]         r_code;
  logic [2:0]         r_tries;
  logic               r_busy;
  logic [2:0]         r_cnt [NUM_ACC];
  logic [NUM_ACC-1:0] r_lock;

  state_t             w_state_nxt;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic [TMR_W-1:0]   w_timer_run;
  logic [TMR_W-1:0]   w_timer_inc;
  logic [3:0]         w_lk_acc_nxt;
  logic [15:0]        w_lk_pin_nxt;
  logic [3:0]         w_acc_idx_nxt;
  logic               w_fail_nxt;
  logic [1:0]         w_code_nxt;
  logic [2:0]         w_tries_nxt;
  logic               w_tbl_wr;
  logic [2:0]         w_cnt_new;
  logic               w_lock_new;
  logic               w_idx_ok;
  logic               w_unlock;
  logic [2:0]         w_cnt_cur;
  logic [2:0]         w_cnt_inc;
  logic               w_locked;
  logic               w_timed_out;

  // Lookup decode, saturating timer and counter helpers.
  always_comb begin
    w_idx_ok    = lk_found && ({1'b0, lk_index} < NUM_ACC_L);
    w_unlock    = admin_unlock && ({1'b0, admin_idx} < NUM_ACC_L);
    w_cnt_cur   = r_cnt[lk_index];
    w_locked    = r_lock[lk_index];
    w_cnt_inc   = (w_cnt_cur >= MAX_T) ? MAX_T : (w_cnt_cur + 3'd1);
    w_timer_inc = (r_timer == TMR_SAT) ? r_timer : (r_timer + TMR_ONE);
    w_timed_out = (r_timer >= TMO_LAST);
  end

  // Next-state, next-output and retry-table update decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_run   = r_timer;
    w_lk_acc_nxt  = r_lk_acc;
    w_lk_pin_nxt  = r_lk_pin;
    w_acc_idx_nxt = r_acc_idx;
    w_fail_nxt    = 1'b0;
    w_code_nxt    = r_code;
    w_tries_nxt   = r_tries;
    w_tbl_wr      = 1'b0;
    w_cnt_new     = 3'd0;
    w_lock_new    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (card_in) begin
          w_state_nxt  = S_WAIT_PIN;
          w_lk_acc_nxt = acc_num_in;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_PIN: begin
        w_timer_run = w_timer_inc;
        if (!card_in || cancel) begin
          w_state_nxt = S_IDLE;
        end else if (w_timed_out) begin
          w_state_nxt = S_HOLD;
          w_fail_nxt  = 1'b1;
          w_code_nxt  = CODE_TMO;
        end else if (pin_valid) begin
          w_state_nxt  = S_LOOKUP;
          w_lk_pin_nxt = pin_in;
        end else begin
          w_state_nxt = S_WAIT_PIN;
        end
      end
      S_LOOKUP: begin
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (!w_idx_ok) begin
          w_state_nxt = S_HOLD;
          w_fail_nxt  = 1'b1;
          w_code_nxt  = CODE_NOACC;
        end else if (w_locked) begin
          w_state_nxt = S_HOLD;
          w_fail_nxt  = 1'b1;
          w_code_nxt  = CODE_LOCK;
          w_tries_nxt = MAX_T - w_cnt_cur;
        end else if (!lk_pin_ok) begin
          w_tbl_wr    = 1'b1;
          w_cnt_new   = w_cnt_inc;
          w_lock_new  = (w_cnt_inc == MAX_T);
          w_fail_nxt  = 1'b1;
          w_tries_nxt = MAX_T - w_cnt_inc;
          if (w_cnt_inc == MAX_T) begin
            w_state_nxt = S_HOLD;
            w_code_nxt  = CODE_LOCK;
          end else begin
            w_state_nxt = S_WAIT_PIN;
            w_code_nxt  = CODE_WRONG;
          end
        end else begin
          w_tbl_wr      = 1'b1;
          w_cnt_new     = 3'd0;
          w_lock_new    = 1'b0;
          w_tries_nxt   = MAX_T;
          w_acc_idx_nxt = lk_index;
          w_state_nxt   = S_GRANTED;
        end
      end
      S_GRANTED: begin
        w_timer_run = txn_activity ? '0 : w_timer_inc;
        if (session_end || cancel || !card_in) begin
          w_state_nxt = S_IDLE;
        end else if (!txn_activity && w_timed_out) begin
          w_state_nxt = S_HOLD;
          w_fail_nxt  = 1'b1;
          w_code_nxt  = CODE_TMO;
        end else begin
          w_state_nxt = S_GRANTED;
        end
      end
      S_HOLD: begin
        if (!card_in) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Every state entry (including a retry from CHECK) restarts the timer.
    if (w_state_nxt != r_state) begin
      w_timer_nxt = '0;
    end else begin
      w_timer_nxt = w_timer_run;
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_lk_acc  <= 4'd0;
      r_lk_pin  <= 16'd0;
      r_sess    <= 1'b0;
      r_acc_idx <= 4'd0;
      r_fail    <= 1'b0;
      r_code    <= 2'b00;
      r_tries   <= MAX_T;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_lk_acc  <= w_lk_acc_nxt;
      r_lk_pin  <= w_lk_pin_nxt;
      r_sess    <= (w_state_nxt == S_GRANTED);
      r_acc_idx <= w_acc_idx_nxt;
      r_fail    <= w_fail_nxt;
      r_code    <= w_code_nxt;
      r_tries   <= w_tries_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  // Retry counters and lock bits; an admin unlock on the same index overrides CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        r_cnt[i] <= 3'd0;
      end
      r_lock <= '0;
    end else begin
      if (w_tbl_wr && w_idx_ok) begin
        r_cnt[lk_index]  <= w_cnt_new;
        r_lock[lk_index] <= w_lock_new;
      end
      if (w_unlock) begin
        r_cnt[admin_idx]  <= 3'd0;
        r_lock[admin_idx] <= 1'b0;
      end
    end
  end

  assign lk_acc_num    = r_lk_acc;
  assign lk_pin        = r_lk_pin;
  assign session_valid = r_sess;
  assign acc_index_out = r_acc_idx;
  assign auth_fail     = r_fail;
  assign fail_code     = r_code;
  assign tries_left    = r_tries;
  assign busy          = r_busy;

endmodule

// File: tb/tb_atm_auth_controller.sv
// Self-checking bench for atm_auth_controller. The lookup block is modelled as a
// small account table (card numbers 1..11 map to indexes 0..10, each with a fixed
// PIN); expected outcomes come from a rule-level model of retries and locks.
module tb_atm_auth_controller;
  localparam int NUM_ACC = 10;
  localparam int MAX     = 3;

  logic        clk = 1'b0;
  logic        rst, card_in, pin_valid, cancel, txn_activity, session_end, admin_unlock;
  logic [3:0]  acc_num_in, admin_idx, lk_acc_num, lk_index, acc_index_out;
  logic [15:0] pin_in, lk_pin;
  logic        lk_found, lk_pin_ok, session_valid, auth_fail, busy;
  logic [1:0]  fail_code;
  logic [2:0]  tries_left;

  int n_checks = 0;
  int n_pass   = 0;
  int m_cnt [NUM_ACC];
  bit m_lock [NUM_ACC];
  int m_tries;

  atm_auth_controller dut (
    .clk(clk), .rst(rst), .card_in(card_in), .acc_num_in(acc_num_in),
    .pin_in(pin_in), .pin_valid(pin_valid), .cancel(cancel),
    .txn_activity(txn_activity), .session_end(session_end),
    .admin_unlock(admin_unlock), .admin_idx(admin_idx),
    .lk_acc_num(lk_acc_num), .lk_pin(lk_pin), .lk_found(lk_found),
    .lk_index(lk_index), .lk_pin_ok(lk_pin_ok), .session_valid(session_valid),
    .acc_index_out(acc_index_out), .auth_fail(auth_fail), .fail_code(fail_code),
    .tries_left(tries_left), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] good_pin(input logic [3:0] i);
    return 16'h1000 + 16'(i) * 16'h0111;
  endfunction

  // Account lookup model.
  always_comb begin
    lk_found  = (lk_acc_num >= 4'd1) && (lk_acc_num <= 4'd11);
    lk_index  = lk_acc_num - 4'd1;
    lk_pin_ok = lk_found && (lk_pin == good_pin(lk_index));
  end

  // Rule-level outcome of one PIN attempt on card number acc.
  function automatic void model_attempt(input int acc, input bit ok,
                                        output int code, output bit grant, output bit retry);
    int idx;
    idx = acc - 1;
    code = 0; grant = 1'b0; retry = 1'b0;
    if (acc < 1 || acc > 11 || idx >= NUM_ACC) begin
      code = 0;
    end else if (m_lock[idx]) begin
      code = 2;
      m_tries = MAX - m_cnt[idx];
    end else if (!ok) begin
      m_cnt[idx] = (m_cnt[idx] < MAX) ? m_cnt[idx] + 1 : MAX;
      m_tries = MAX - m_cnt[idx];
      if (m_cnt[idx] == MAX) begin m_lock[idx] = 1'b1; code = 2; end
      else begin code = 1; retry = 1'b1; end
    end else begin
      m_cnt[idx] = 0;
      m_tries = MAX;
      grant = 1'b1;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NUM_ACC; i++) begin m_cnt[i] = 0; m_lock[i] = 1'b0; end
    m_tries = MAX;
  endfunction

  task automatic tick; @(posedge clk); #1; endtask

  task automatic do_reset;
    rst = 1'b1; card_in = 1'b0; pin_valid = 1'b0; cancel = 1'b0; txn_activity = 1'b0;
    session_end = 1'b0; admin_unlock = 1'b0; acc_num_in = 4'd0; admin_idx = 4'd0; pin_in = 16'd0;
    tick; tick;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic insert(input int acc);
    card_in = 1'b1; acc_num_in = 4'(acc); tick;
  endtask

  task automatic enter_pin(input logic [15:0] p);
    pin_in = p; pin_valid = 1'b1; tick; pin_valid = 1'b0; tick; tick;
  endtask

  task automatic end_card;
    card_in = 1'b0; session_end = 1'b1; tick; session_end = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++;
    if ({session_valid, auth_fail, busy, fail_code, tries_left, acc_index_out, lk_acc_num, lk_pin}
        !== {1'b0, 1'b0, 1'b0, 2'b00, 3'd3, 4'd0, 4'd0, 16'd0})
      $display("FAIL reset_state got sv=%b af=%b busy=%b code=%b tries=%0d idx=%0d exp 0/0/0/00/3/0",
               session_valid, auth_fail, busy, fail_code, tries_left, acc_index_out);
    else n_pass++;
  endtask

  task automatic test_grant;
    int c; bit g, r;
    insert(3);
    n_checks++;
    if ({busy, lk_acc_num} !== {1'b1, 4'd3}) $display("FAIL grant_latch got busy=%b acc=%0d exp 1/3", busy, lk_acc_num);
    else n_pass++;
    model_attempt(3, 1'b1, c, g, r);
    pin_in = good_pin(4'd2); pin_valid = 1'b1; tick; pin_valid = 1'b0; tick;
    n_checks++;
    if (session_valid !== 1'b0) $display("FAIL grant_early got sv=%b exp 0", session_valid);
    else n_pass++;
    tick;
    n_checks++;
    if ({session_valid, auth_fail, acc_index_out, tries_left} !== {1'b1, 1'b0, 4'd2, 3'd3})
      $display("FAIL grant_3cyc got sv=%b af=%b idx=%0d tries=%0d exp 1/0/2/3", session_valid, auth_fail, acc_index_out, tries_left);
    else n_pass++;
    end_card;
    n_checks++;
    if ({session_valid, busy} !== 2'b00) $display("FAIL grant_end got sv=%b busy=%b exp 0/0", session_valid, busy);
    else n_pass++;
  endtask

  task automatic test_lockout;
    int ec [3] = '{1, 1, 2};
    int et [3] = '{2, 1, 0};
    int c; bit g, r;
    insert(5);
    for (int k = 0; k < 3; k++) begin
      model_attempt(5, 1'b0, c, g, r);
      enter_pin(good_pin(4'd4) ^ 16'h0001);
      n_checks++;
      if ({session_valid, auth_fail, fail_code, tries_left} !== {1'b0, 1'b1, 2'(ec[k]), 3'(et[k])})
        $display("FAIL lockout_try%0d got sv=%b af=%b code=%b tries=%0d exp 0/1/%0d/%0d",
                 k, session_valid, auth_fail, fail_code, tries_left, ec[k], et[k]);
      else n_pass++;
    end
    pin_valid = 1'b1; cancel = 1'b1; txn_activity = 1'b1; tick;
    pin_valid = 1'b0; cancel = 1'b0; txn_activity = 1'b0;
    repeat (3) tick;
    n_checks++;
    if ({busy, session_valid, auth_fail} !== 3'b100) $display("FAIL hold_ignores got busy=%b sv=%b af=%b exp 1/0/0", busy, session_valid, auth_fail);
    else n_pass++;
    end_card;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL hold_exit got busy=%b exp 0", busy);
    else n_pass++;
    insert(5);
    model_attempt(5, 1'b1, c, g, r);
    enter_pin(good_pin(4'd4));
    n_checks++;
    if ({session_valid, auth_fail, fail_code, tries_left} !== {1'b0, 1'b1, 2'b10, 3'd0})
      $display("FAIL locked_correct got sv=%b af=%b code=%b tries=%0d exp 0/1/10/0", session_valid, auth_fail, fail_code, tries_left);
    else n_pass++;
    end_card;
  endtask

  task automatic test_admin;
    int c; bit g, r;
    admin_idx = 4'd4; admin_unlock = 1'b1; tick; admin_unlock = 1'b0;
    m_cnt[4] = 0; m_lock[4] = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL unlock_state got busy=%b exp 0", busy);
    else n_pass++;
    insert(5);
    model_attempt(5, 1'b1, c, g, r);
    enter_pin(good_pin(4'd4));
    n_checks++;
    if ({session_valid, acc_index_out} !== {1'b1, 4'd4}) $display("FAIL unlock_grant got sv=%b idx=%0d exp 1/4", session_valid, acc_index_out);
    else n_pass++;
    end_card;
    insert(5);
    model_attempt(5, 1'b0, c, g, r);
    enter_pin(16'hDEAD);
    model_attempt(5, 1'b0, c, g, r);
    m_cnt[4] = 0; m_lock[4] = 1'b0;
    pin_in = 16'hBEEF; pin_valid = 1'b1; tick; pin_valid = 1'b0; tick;
    admin_unlock = 1'b1; admin_idx = 4'd4; tick; admin_unlock = 1'b0;
    n_checks++;
    if ({auth_fail, fail_code} !== {1'b1, 2'b01}) $display("FAIL unlock_coinc got af=%b code=%b exp 1/01", auth_fail, fail_code);
    else n_pass++;
    model_attempt(5, 1'b0, c, g, r);
    enter_pin(16'hCAFE);
    n_checks++;
    if ({auth_fail, fail_code, tries_left} !== {1'b1, 2'(c), 3'(m_tries)})
      $display("FAIL unlock_after got af=%b code=%b tries=%0d exp 1/%0d/%0d", auth_fail, fail_code, tries_left, c, m_tries);
    else n_pass++;
    end_card;
  endtask

  task automatic test_unknown;
    int c; bit g, r;
    insert(0);
    model_attempt(0, 1'b1, c, g, r);
    enter_pin(16'h1234);
    n_checks++;
    if ({session_valid, auth_fail, fail_code} !== {1'b0, 1'b1, 2'b00}) $display("FAIL noacc got sv=%b af=%b code=%b exp 0/1/00", session_valid, auth_fail, fail_code);
    else n_pass++;
    repeat (5) tick;
    n_checks++;
    if ({busy, auth_fail} !== 2'b10) $display("FAIL noacc_hold got busy=%b af=%b exp 1/0", busy, auth_fail);
    else n_pass++;
    end_card;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL noacc_exit got busy=%b exp 0", busy);
    else n_pass++;
    insert(11);
    model_attempt(11, 1'b1, c, g, r);
    enter_pin(good_pin(4'd10));
    n_checks++;
    if ({session_valid, auth_fail, fail_code} !== {1'b0, 1'b1, 2'b00}) $display("FAIL idx_range got sv=%b af=%b code=%b exp 0/1/00", session_valid, auth_fail, fail_code);
    else n_pass++;
    end_card;
  endtask

  task automatic test_timeout;
    int n, c; bit g, r;
    insert(7);
    n = 0;
    while (auth_fail !== 1'b1 && n < 1100) begin tick; n++; end
    n_checks++;
    if (n != 1000 || fail_code !== 2'b11 || busy !== 1'b1) $display("FAIL wait_timeout got cyc=%0d code=%b exp 1000/11", n, fail_code);
    else n_pass++;
    end_card;
    insert(7);
    model_attempt(7, 1'b1, c, g, r);
    enter_pin(good_pin(4'd6));
    for (int k = 0; k < 10; k++) begin
      repeat (499) tick;
      txn_activity = 1'b1; tick; txn_activity = 1'b0;
    end
    n_checks++;
    if ({session_valid, auth_fail} !== 2'b10) $display("FAIL keepalive got sv=%b af=%b exp 1/0", session_valid, auth_fail);
    else n_pass++;
    n = 0;
    while (auth_fail !== 1'b1 && n < 1100) begin tick; n++; end
    n_checks++;
    if (n != 1000 || {session_valid, fail_code} !== {1'b0, 2'b11}) $display("FAIL sess_timeout got cyc=%0d sv=%b code=%b exp 1000/0/11", n, session_valid, fail_code);
    else n_pass++;
    end_card;
  endtask

  task automatic test_random;
    int acc, c, ai; bit ok, g, r, done;
    for (int s = 0; s < 30; s++) begin
      acc = $urandom_range(0, 15);
      insert(acc);
      done = 1'b0;
      for (int a = 0; a < 4 && !done; a++) begin
        ok = ($urandom_range(0, 2) == 0);
        model_attempt(acc, ok, c, g, r);
        enter_pin(ok ? good_pin(4'(acc - 1)) : (good_pin(4'(acc - 1)) ^ 16'(1 << $urandom_range(0, 15))));
        n_checks++;
        if (g) begin
          if ({session_valid, auth_fail, acc_index_out, tries_left} !== {1'b1, 1'b0, 4'(acc - 1), 3'd3})
            $display("FAIL rand_grant acc=%0d got sv=%b af=%b idx=%0d tries=%0d", acc, session_valid, auth_fail, acc_index_out, tries_left);
          else n_pass++;
        end else begin
          if ({session_valid, auth_fail, fail_code, tries_left} !== {1'b0, 1'b1, 2'(c), 3'(m_tries)})
            $display("FAIL rand_fail acc=%0d got af=%b code=%b tries=%0d exp 1/%0d/%0d", acc, auth_fail, fail_code, tries_left, c, m_tries);
          else n_pass++;
        end
        done = !r;
      end
      end_card;
      if ($urandom_range(0, 3) == 0) begin
        ai = $urandom_range(0, 15);
        admin_idx = 4'(ai); admin_unlock = 1'b1; tick; admin_unlock = 1'b0;
        if (ai < NUM_ACC) begin m_cnt[ai] = 0; m_lock[ai] = 1'b0; end
      end
    end
  endtask

  task automatic test_reset_mid;
    int c; bit g, r;
    insert(8);
    for (int k = 0; k < 3; k++) begin model_attempt(8, 1'b0, c, g, r); enter_pin(16'h0F0F); end
    end_card;
    insert(2);
    enter_pin(good_pin(4'd1));
    rst = 1'b1; card_in = 1'b0; tick; rst = 1'b0;
    model_clear();
    n_checks++;
    if ({session_valid, auth_fail, busy, fail_code, tries_left, acc_index_out, lk_acc_num, lk_pin}
        !== {1'b0, 1'b0, 1'b0, 2'b00, 3'd3, 4'd0, 4'd0, 16'd0})
      $display("FAIL rst_granted got sv=%b busy=%b code=%b tries=%0d idx=%0d", session_valid, busy, fail_code, tries_left, acc_index_out);
    else n_pass++;
    insert(8);
    pin_in = good_pin(4'd7); pin_valid = 1'b1; tick; pin_valid = 1'b0;
    rst = 1'b1; card_in = 1'b0; tick; rst = 1'b0;
    n_checks++;
    if ({busy, tries_left, lk_acc_num, lk_pin} !== {1'b0, 3'd3, 4'd0, 16'd0})
      $display("FAIL rst_lookup got busy=%b tries=%0d acc=%0d pin=%h", busy, tries_left, lk_acc_num, lk_pin);
    else n_pass++;
    insert(8);
    model_attempt(8, 1'b1, c, g, r);
    enter_pin(good_pin(4'd7));
    n_checks++;
    if ({session_valid, acc_index_out} !== {1'b1, 4'd7}) $display("FAIL rst_unlocks got sv=%b idx=%0d exp 1/7", session_valid, acc_index_out);
    else n_pass++;
    end_card;
  endtask

  initial begin
    test_reset;
    test_grant;
    test_lockout;
    test_admin;
    test_unknown;
    test_timeout;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired after %0d of %0d checks", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
